// File: rtl/viterbi_byte_fifo.sv
// rtl/viterbi_byte_fifo.sv - FWFT byte FIFO with packet-last tagging after the Viterbi SIPO packer
module viterbi_byte_fifo #(
  parameter int DEPTH     = 16,
  parameter int PKT_BYTES = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [7:0]                 byte_i,
  input  logic                       byte_valid_i,
  input  logic                       flush_i,
  output logic [7:0]                 m_data_o,
  output logic                       m_valid_o,
  input  logic                       m_ready_i,
  output logic                       m_last_o,
  output logic [$clog2(DEPTH):0]     level_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic                       overflow_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int PW = (PKT_BYTES > 1) ? $clog2(PKT_BYTES) : 1;

  logic [8:0]    mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic          full_q, full_d, empty_q, empty_d, valid_q, valid_d, ovf_q, ovf_d;
  logic          pop, push, drop, last_in, wr_en;

  assign pop     = valid_q && m_ready_i;
  assign push    = byte_valid_i && (!full_q || pop);
  assign drop    = byte_valid_i && full_q && !pop;
  assign last_in = (pcnt_q == PW'(PKT_BYTES - 1));
  assign wr_en   = push && !flush_i;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    pcnt_d  = pcnt_q;
    ovf_d   = ovf_q;
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      level_d = '0;
      pcnt_d  = '0;
      ovf_d   = 1'b0;
    end else begin
      if (push) begin
        wptr_d = wptr_q + 1'b1;
        pcnt_d = last_in ? '0 : pcnt_q + 1'b1;
      end
      if (pop) rptr_d = rptr_q + 1'b1;
      if (push && !pop) level_d = level_q + 1'b1;
      else if (pop && !push) level_d = level_q - 1'b1;
      if (drop) ovf_d = 1'b1;
    end
    // Status flags are registered alongside the level they are decoded from.
    full_d  = (level_d == LW'(DEPTH));
    empty_d = (level_d == '0);
    valid_d = !empty_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      pcnt_q  <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      pcnt_q  <= pcnt_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

  // Storage carries no reset; the head is masked by valid so stale entries never leak out.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wptr_q] <= {last_in, byte_i};
  end

  assign m_valid_o  = valid_q;
  assign m_data_o   = valid_q ? mem_q[rptr_q][7:0] : 8'd0;
  assign m_last_o   = valid_q ? mem_q[rptr_q][8]   : 1'b0;
  assign level_o    = level_q;
  assign full_o     = full_q;
  assign empty_o    = empty_q;
  assign overflow_o = ovf_q;

endmodule

// File: tb/tb_viterbi_byte_fifo.sv
// tb/tb_viterbi_byte_fifo.sv - self-checking bench for viterbi_byte_fifo against a queue model
module tb_viterbi_byte_fifo;
  localparam int DEPTH = 16;
  localparam int PKT   = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] byte_i = '0;
  logic       byte_valid_i = 1'b0;
  logic       flush_i = 1'b0;
  logic [7:0] m_data_o;
  logic       m_valid_o;
  logic       m_ready_i = 1'b0;
  logic       m_last_o;
  logic [4:0] level_o;
  logic       full_o, empty_o, overflow_o;

  int n_checks = 0;
  int n_fail   = 0;

  logic [8:0] mq[$];
  int         m_pcnt = 0;
  logic       m_ovf = 1'b0;

  viterbi_byte_fifo #(.DEPTH(DEPTH), .PKT_BYTES(PKT)) dut (
    .clk(clk), .rst_n(rst_n), .byte_i(byte_i), .byte_valid_i(byte_valid_i),
    .flush_i(flush_i), .m_data_o(m_data_o), .m_valid_o(m_valid_o),
    .m_ready_i(m_ready_i), .m_last_o(m_last_o), .level_o(level_o),
    .full_o(full_o), .empty_o(empty_o), .overflow_o(overflow_o)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] exp_data();
    return (mq.size() > 0) ? mq[0][7:0] : 8'd0;
  endfunction
  function automatic logic exp_last();
    return (mq.size() > 0) ? mq[0][8] : 1'b0;
  endfunction

  function automatic void model_reset();
    mq.delete();
    m_pcnt = 0;
    m_ovf  = 1'b0;
  endfunction

  // One clock cycle: drive at negedge, apply the behavioural rules at posedge, return at next negedge.
  task automatic cyc(input logic bv, input logic [7:0] b, input logic rdy, input logic fl);
    logic pop, full, lst;
    byte_valid_i = bv;
    byte_i       = b;
    m_ready_i    = rdy;
    flush_i      = fl;
    pop  = (mq.size() > 0) && rdy;
    full = (mq.size() == DEPTH);
    @(posedge clk);
    if (fl) begin
      model_reset();
    end else begin
      if (pop) void'(mq.pop_front());
      if (bv) begin
        if (full && !pop) m_ovf = 1'b1;
        else begin
          lst = (m_pcnt == PKT - 1);
          mq.push_back({lst, b});
          m_pcnt = lst ? 0 : m_pcnt + 1;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    n_checks++; if (m_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %0b exp 0", m_valid_o); end
    n_checks++; if (m_data_o !== 8'd0) begin n_fail++; $display("FAIL reset_data got %0h exp 0", m_data_o); end
    n_checks++; if (m_last_o !== 1'b0) begin n_fail++; $display("FAIL reset_last got %0b exp 0", m_last_o); end
    n_checks++; if (level_o !== 5'd0) begin n_fail++; $display("FAIL reset_level got %0d exp 0", level_o); end
    n_checks++; if ({full_o, empty_o, overflow_o} !== 3'b010) begin
      n_fail++; $display("FAIL reset_flags got %b exp 010", {full_o, empty_o, overflow_o}); end
  endtask

  task automatic test_alternate();
    logic [7:0] a [4];
    a[0] = 8'hA0; a[1] = 8'hA1; a[2] = 8'hA2; a[3] = 8'hA3;
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, a[i], 1'b1, 1'b0);
      n_checks++; if (m_valid_o !== 1'b1 || m_data_o !== a[i]) begin
        n_fail++; $display("FAIL alt_data[%0d] got v=%0b d=%0h exp v=1 d=%0h", i, m_valid_o, m_data_o, a[i]); end
      n_checks++; if (m_last_o !== (i == 3)) begin
        n_fail++; $display("FAIL alt_last[%0d] got %0b exp %0b", i, m_last_o, (i == 3)); end
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
    end
    n_checks++; if (level_o !== 5'd0 || empty_o !== 1'b1) begin
      n_fail++; $display("FAIL alt_level got %0d/%0b exp 0/1", level_o, empty_o); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 17; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0);
    n_checks++; if (level_o !== 5'd16 || full_o !== 1'b1) begin
      n_fail++; $display("FAIL ovf_level got %0d full=%0b exp 16 full=1", level_o, full_o); end
    n_checks++; if (overflow_o !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got %0b exp 1", overflow_o); end
    for (int i = 0; i < 16; i++) begin
      n_checks++; if (m_valid_o !== 1'b1 || m_data_o !== 8'(i) || m_last_o !== ((i % 4) == 3)) begin
        n_fail++; $display("FAIL ovf_drain[%0d] got v=%0b d=%0h l=%0b exp v=1 d=%0h l=%0b",
                           i, m_valid_o, m_data_o, m_last_o, 8'(i), ((i % 4) == 3)); end
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
    end
    n_checks++; if (empty_o !== 1'b1 || overflow_o !== 1'b1) begin
      n_fail++; $display("FAIL ovf_after got empty=%0b ovf=%0b exp 1/1", empty_o, overflow_o); end
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic test_full_pushpop();
    for (int i = 0; i < 16; i++) cyc(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
    cyc(1'b1, 8'h55, 1'b1, 1'b0);
    n_checks++; if (level_o !== 5'd16 || overflow_o !== 1'b0) begin
      n_fail++; $display("FAIL full_pp got level=%0d ovf=%0b exp 16/0", level_o, overflow_o); end
    for (int i = 0; i < 16; i++) begin
      n_checks++; if (m_data_o !== exp_data() || m_last_o !== exp_last()) begin
        n_fail++; $display("FAIL full_pp_drain[%0d] got %0h/%0b exp %0h/%0b", i, m_data_o, m_last_o, exp_data(), exp_last()); end
      if (i == 15) begin
        n_checks++; if (m_data_o !== 8'h55) begin n_fail++; $display("FAIL full_pp_55 got %0h exp 55", m_data_o); end
      end
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
    end
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic test_backpressure();
    logic [7:0] hd;
    logic hl, hv;
    for (int i = 0; i < 24; i++) begin
      hd = m_data_o; hl = m_last_o; hv = m_valid_o;
      cyc((i < 8), 8'(8'h80 + i), (i % 2 == 0), 1'b0);
      if (i % 2 == 1 && hv) begin
        n_checks++; if (m_data_o !== hd || m_last_o !== hl) begin
          n_fail++; $display("FAIL bp_stable[%0d] got %0h/%0b exp %0h/%0b", i, m_data_o, m_last_o, hd, hl); end
      end
      n_checks++; if (m_data_o !== exp_data() || m_last_o !== exp_last() || level_o !== 5'(mq.size())) begin
        n_fail++; $display("FAIL bp_model[%0d] got %0h/%0b/%0d exp %0h/%0b/%0d", i, m_data_o, m_last_o, level_o,
                           exp_data(), exp_last(), mq.size()); end
    end
  endtask

  task automatic test_flush();
    cyc(1'b1, 8'h11, 1'b0, 1'b0);
    cyc(1'b1, 8'h12, 1'b0, 1'b0);
    cyc(1'b1, 8'h13, 1'b0, 1'b1);
    n_checks++; if (empty_o !== 1'b1 || overflow_o !== 1'b0 || m_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL flush got empty=%0b ovf=%0b valid=%0b exp 1/0/0", empty_o, overflow_o, m_valid_o); end
    for (int i = 0; i < 4; i++) cyc(1'b1, 8'(8'hB0 + i), 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (m_data_o !== 8'(8'hB0 + i) || m_last_o !== (i == 3)) begin
        n_fail++; $display("FAIL flush_b[%0d] got %0h/%0b exp %0h/%0b", i, m_data_o, m_last_o, 8'(8'hB0 + i), (i == 3)); end
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
    byte_valid_i = 1'b0;
    m_ready_i    = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    n_checks++; if ({m_valid_o, m_data_o, m_last_o} !== 10'd0 || level_o !== 5'd0 || empty_o !== 1'b1) begin
      n_fail++; $display("FAIL async_rst got v=%0b d=%0h l=%0b lvl=%0d e=%0b exp 0/0/0/0/1",
                         m_valid_o, m_data_o, m_last_o, level_o, empty_o); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      n_checks++; if (m_valid_o !== 1'b0 || m_data_o !== 8'd0) begin
        n_fail++; $display("FAIL async_stale[%0d] got v=%0b d=%0h exp 0/0", i, m_valid_o, m_data_o); end
    end
    cyc(1'b1, 8'h5A, 1'b0, 1'b0);
    n_checks++; if (m_data_o !== 8'h5A || m_last_o !== 1'b0) begin
      n_fail++; $display("FAIL async_restart got %0h/%0b exp 5a/0", m_data_o, m_last_o); end
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      cyc(1'($urandom_range(0, 99) < 60), 8'($urandom), 1'($urandom_range(0, 99) < 40),
          1'($urandom_range(0, 99) < 2));
      n_checks++; if (m_valid_o !== (mq.size() > 0) || m_data_o !== exp_data() || m_last_o !== exp_last()) begin
        n_fail++; $display("FAIL rnd_head[%0d] got %0b/%0h/%0b exp %0b/%0h/%0b", i, m_valid_o, m_data_o, m_last_o,
                           (mq.size() > 0), exp_data(), exp_last()); end
      n_checks++; if (level_o !== 5'(mq.size()) || full_o !== (mq.size() == DEPTH) ||
                      empty_o !== (mq.size() == 0) || overflow_o !== m_ovf) begin
        n_fail++; $display("FAIL rnd_status[%0d] got %0d/%0b/%0b/%0b exp %0d/%0b/%0b/%0b", i, level_o, full_o,
                           empty_o, overflow_o, mq.size(), (mq.size() == DEPTH), (mq.size() == 0), m_ovf); end
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_alternate();
    test_overflow();
    test_full_pushpop();
    test_backpressure();
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    test_flush();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end
endmodule
